// File: rtl/track_select.sv
// Front-panel track selector: debounces the NEXT/PREV buttons and issues one
// valid/ready command per press while tracking the current track index.
module track_select #(
   parameter int NUM_TRACKS   = 8,
   parameter int DEBOUNCE_CYC = 4,
   localparam int TW          = $clog2(NUM_TRACKS)
) (
   input  logic          clk,
   input  logic          RST,
   input  logic          next_n,
   input  logic          prev_n,
   input  logic          cmd_rdy,
   output logic          cmd_vld,
   output logic          cmd_op,
   output logic [TW-1:0] cmd_track,
   output logic [TW-1:0] track,
   output logic          drop
);

   localparam int            CW       = $clog2(DEBOUNCE_CYC);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
   localparam logic [TW-1:0] TRK_LAST = TW'(NUM_TRACKS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_e;

   // Bit 0 carries NEXT, bit 1 carries PREV through the whole button pipeline.
   logic [1:0]    btn_raw;
   logic [1:0]    sync1_q;
   logic [1:0]    sync2_q;
   logic [1:0]    deb_q;
   logic [1:0]    deb_d;
   logic [1:0]    deb_dly_q;
   logic [1:0]    press;
   logic [CW-1:0] cnt_q [2];
   logic [CW-1:0] cnt_d [2];

   assign btn_raw = {prev_n, next_n};

   always_comb begin
      for (int unsigned i = 0; i < 2; i++) begin
         deb_d[i] = deb_q[i];
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               deb_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         deb_q     <= '1;
         deb_dly_q <= '1;
         for (int unsigned i = 0; i < 2; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q   <= btn_raw;
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         for (int unsigned i = 0; i < 2; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Press is taken from the registered level, so the FSM acts one edge after the fall.
   assign press = deb_dly_q & ~deb_q;

   state_e        state_q, state_d;
   logic          op_q, op_d;
   logic [TW-1:0] ct_q, ct_d;
   logic [TW-1:0] trk_q, trk_d;
   logic          drop_q, drop_d;
   logic [TW-1:0] trk_inc;
   logic [TW-1:0] trk_dec;

   assign trk_inc = (trk_q == TRK_LAST) ? '0 : trk_q + 1'b1;
   assign trk_dec = (trk_q == '0) ? TRK_LAST : trk_q - 1'b1;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      ct_d    = ct_q;
      trk_d   = trk_q;
      drop_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (&press) begin
               drop_d = 1'b1;
            end else if (press[0]) begin
               state_d = PEND;
               op_d    = 1'b0;
               ct_d    = trk_inc;
            end else if (press[1]) begin
               state_d = PEND;
               op_d    = 1'b1;
               ct_d    = trk_dec;
            end
         end
         PEND: begin
            drop_d = |press;
            if (cmd_rdy) begin
               trk_d   = ct_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q <= IDLE;
         op_q    <= 1'b0;
         ct_q    <= '0;
         trk_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         ct_q    <= ct_d;
         trk_q   <= trk_d;
         drop_q  <= drop_d;
      end
   end

   assign cmd_vld   = (state_q == PEND);
   assign cmd_op    = op_q;
   assign cmd_track = ct_q;
   assign track     = trk_q;
   assign drop      = drop_q;

endmodule

// File: tb/tb_track_select.sv
// Bench for track_select: directed scenarios plus random button/ready traffic,
// every cycle compared against a history-window reference model.
module tb_track_select;

   localparam int N  = 8;
   localparam int D  = 4;
   localparam int TW = $clog2(N);

   logic          clk = 1'b0;
   logic          RST;
   logic          next_n;
   logic          prev_n;
   logic          cmd_rdy;
   logic          cmd_vld;
   logic          cmd_op;
   logic [TW-1:0] cmd_track;
   logic [TW-1:0] track;
   logic          drop;

   track_select #(.NUM_TRACKS(N), .DEBOUNCE_CYC(D)) dut (
      .clk      (clk),
      .RST      (RST),
      .next_n   (next_n),
      .prev_n   (prev_n),
      .cmd_rdy  (cmd_rdy),
      .cmd_vld  (cmd_vld),
      .cmd_op   (cmd_op),
      .cmd_track(cmd_track),
      .track    (track),
      .drop     (drop)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ncmd   = 0;
   int ndrop  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: raw samples kept newest-first; the debounced level flips
   // once the last D synchronized samples all disagree with it.
   bit m_hist [2][D+1];
   bit m_deb  [2];
   bit m_fell [2];
   bit m_pend, m_op, m_drop;
   int m_ct, m_track;

   task automatic model_step();
      bit btn [2];
      bit ev  [2];
      bit all_diff;
      btn[0] = next_n;
      btn[1] = prev_n;
      if (RST) begin
         for (int b = 0; b < 2; b++) begin
            for (int j = 0; j <= D; j++) m_hist[b][j] = 1'b1;
            m_deb[b]  = 1'b1;
            m_fell[b] = 1'b0;
         end
         m_pend = 0; m_op = 0; m_ct = 0; m_track = 0; m_drop = 0;
         return;
      end
      ev[0] = m_fell[0];
      ev[1] = m_fell[1];
      for (int b = 0; b < 2; b++) begin
         all_diff = 1'b1;
         for (int j = 1; j <= D; j++) if (m_hist[b][j] == m_deb[b]) all_diff = 1'b0;
         m_fell[b] = 1'b0;
         if (all_diff) begin
            m_fell[b] = m_deb[b];
            m_deb[b]  = ~m_deb[b];
         end
         for (int j = D; j >= 1; j--) m_hist[b][j] = m_hist[b][j-1];
         m_hist[b][0] = btn[b];
      end
      m_drop = 0;
      if (m_pend) begin
         if (ev[0] || ev[1]) m_drop = 1;
         if (cmd_rdy) begin
            m_track = m_ct;
            m_pend  = 0;
         end
      end else if (ev[0] && ev[1]) begin
         m_drop = 1;
      end else if (ev[0]) begin
         m_pend = 1; m_op = 0; m_ct = (m_track + 1) % N;
      end else if (ev[1]) begin
         m_pend = 1; m_op = 1; m_ct = (m_track + N - 1) % N;
      end
   endtask

   task automatic cycle();
      bit hs;
      hs = (cmd_vld === 1'b1) && (cmd_rdy === 1'b1) && (RST === 1'b0);
      @(posedge clk);
      model_step();
      #1;
      if (hs) ncmd++;
      if (drop === 1'b1) ndrop++;
      check("cmd_vld", cmd_vld, m_pend);
      check("cmd_op", cmd_op, m_op);
      check("cmd_track", cmd_track, m_ct);
      check("track", track, m_track);
      check("drop", drop, m_drop);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset(input int n);
      RST = 1'b1;
      cycles(n);
      RST = 1'b0;
   endtask

   initial begin
      int base_cmd, base_drop, lat;
      int run [2];

      RST = 1'b1; next_n = 1'b1; prev_n = 1'b1; cmd_rdy = 1'b1;

      // Reset then a long clean NEXT press
      do_reset(2);
      check("rst_vld", cmd_vld, 0);
      check("rst_track", track, 0);
      base_cmd = ncmd;
      next_n = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         cycle();
         if (lat == 0 && cmd_vld === 1'b1) lat = i;
      end
      check("press_latency", lat, 7);
      next_n = 1'b1;
      cycles(10);
      check("clean_cmds", ncmd - base_cmd, 1);
      check("clean_track", track, 1);

      // Wrap-around both directions
      do_reset(1);
      prev_n = 1'b0; cycles(10); prev_n = 1'b1; cycles(8);
      check("wrap_prev", track, N - 1);
      next_n = 1'b0; cycles(10); next_n = 1'b1; cycles(8);
      check("wrap_next", track, 0);

      // Bounce rejection
      base_cmd = ncmd; base_drop = ndrop;
      for (int i = 0; i < 10; i++) begin
         next_n = i[0];
         cycles(2);
      end
      check("bounce_none", ncmd - base_cmd, 0);
      next_n = 1'b0; cycles(12); next_n = 1'b1; cycles(8);
      check("bounce_cmds", ncmd - base_cmd, 1);
      check("bounce_drop", ndrop - base_drop, 0);

      // Backpressure with a PREV press discarded while pending
      do_reset(1);
      cmd_rdy = 1'b0; base_drop = ndrop; base_cmd = ncmd;
      next_n = 1'b0; cycles(10); next_n = 1'b1; cycles(8);
      prev_n = 1'b0; cycles(10); prev_n = 1'b1; cycles(6);
      check("bp_vld", cmd_vld, 1);
      check("bp_op", cmd_op, 0);
      check("bp_ctrack", cmd_track, 1);
      check("bp_drop", ndrop - base_drop, 1);
      cmd_rdy = 1'b1; cycles(4);
      check("bp_cmds", ncmd - base_cmd, 1);
      check("bp_track", track, 1);

      // Simultaneous presses
      base_drop = ndrop; base_cmd = ncmd;
      next_n = 1'b0; prev_n = 1'b0; cycles(12);
      next_n = 1'b1; prev_n = 1'b1; cycles(8);
      check("sim_drop", ndrop - base_drop, 1);
      check("sim_cmds", ncmd - base_cmd, 0);
      check("sim_track", track, 1);

      // Reset while pending, button still held afterwards
      do_reset(1);
      cmd_rdy = 1'b0;
      next_n = 1'b0; cycles(8);
      check("mid_pend", cmd_vld, 1);
      base_cmd = ncmd;
      RST = 1'b1; cmd_rdy = 1'b1;
      cycle();
      RST = 1'b0;
      check("mid_vld", cmd_vld, 0);
      check("mid_track", track, 0);
      cycles(12);
      next_n = 1'b1; cycles(8);
      check("mid_cmds", ncmd - base_cmd, 1);
      check("mid_track_after", track, 1);

      // Randomized traffic
      run[0] = 1; run[1] = 1;
      for (int i = 0; i < 3000; i++) begin
         if (--run[0] == 0) begin next_n = ~next_n; run[0] = $urandom_range(1, 9); end
         if (--run[1] == 0) begin prev_n = ~prev_n; run[1] = $urandom_range(1, 9); end
         cmd_rdy = ($urandom_range(0, 3) != 0);
         RST     = ($urandom_range(0, 299) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
